screen_driver: RTL and testbench
================================

SCREEN_DRIVER -- requirements
Module: screen_driver

Interface
REQ-001 Parameter STARTUP_WAIT, default 32'd10_000_000, clk cycles per power-up phase (>=1).
REQ-002 clk  input  1  system clock; all logic rising-edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 io_sclk  output  1  SPI clock to SSD1306; idle high.
REQ-005 io_sdin  output  1  SPI data, MSB first.
REQ-006 io_cs  output  1  chip select, active-low.
REQ-007 io_dc  output  1  0 = command byte, 1 = display-data byte.
REQ-008 io_reset  output  1  panel reset, active-low.
REQ-009 pixel_address  output  10  byte index 0..1023 requested from the text engine (bits [9:7] page, [6:0] column).
REQ-010 pixel_data  input  8  byte for pixel_address; valid one clk after pixel_address changes.

Function
REQ-011 States SHALL be: POWER_UP, LOAD_CMD, SEND, CHECK_INIT_DONE, LOAD_DATA.
REQ-012 POWER_UP: counter c from 0; io_reset=1 for c<STARTUP_WAIT, 0 for c<2*STARTUP_WAIT, 1 for c<3*STARTUP_WAIT; at c=3*STARTUP_WAIT SHALL clear c and go to LOAD_CMD.
REQ-013 Init ROM SHALL hold 15 bytes in order: AE D5 80 A8 3F D3 00 40 8D 14 20 00 A1 C8 AF (horizontal addressing mode).
REQ-014 LOAD_CMD: io_dc=0, shift register <= ROM[cmd_index], cmd_index++, bit counter=7, go SEND.
REQ-015 SEND: each bit takes exactly 2 clk: phase 0 io_sclk=0, io_cs=0, io_sdin=shift[bit]; phase 1 io_sclk=1; after bit 0 phase 1, go CHECK_INIT_DONE, else bit--.
REQ-016 One byte SHALL occupy exactly 16 clk in SEND; io_cs SHALL stay low across back-to-back bytes.
REQ-017 CHECK_INIT_DONE: if io_dc=1 or cmd_index=15 go LOAD_DATA, else LOAD_CMD.
REQ-018 LOAD_DATA: io_dc=1, shift register <= pixel_data, pixel_address <= pixel_address+1 (10-bit wrap 1023->0), go SEND.
REQ-019 pixel_address SHALL be held stable for >=16 clk before sampling; first data byte sent SHALL be the byte for address 0.
REQ-020 After init, frames SHALL repeat indefinitely with no gap other than one CHECK_INIT_DONE + one LOAD_DATA cycle per byte (18 clk/byte).
REQ-021 Init commands SHALL be sent exactly once per reset.
REQ-022 io_sdin SHALL change only while io_sclk=0; io_dc SHALL change only between bytes.

Reset
REQ-023 On reset assertion, immediately: state=POWER_UP, c=0, cmd_index=0, io_reset=1, io_cs=1, io_sclk=1, io_sdin=0, io_dc=0, pixel_address=0.
REQ-024 Reset mid-byte or mid-frame SHALL abort transfer and restart full power-up and init sequence.

Structure
REQ-025 Package screen_pkg SHALL hold the state enum, INIT_CMD_COUNT=15 and the init ROM constant.
REQ-026 Bit-serialiser MAY be a sub-module spi_byte_tx (load, byte, busy, sclk, sdin); FSM stays in screen_driver.

Verification (STARTUP_WAIT=4)
REQ-027 Reset release -> io_reset high 4 clk, low 4 clk, high 4 clk, then io_cs falls.
REQ-028 Capture on io_sclk rising edges with io_dc=0 -> exactly 15 bytes AE D5 80 A8 3F D3 00 40 8D 14 20 00 A1 C8 AF.
REQ-029 pixel_data driven = pixel_address[7:0] (1-clk latency model) -> data bytes 00,01,..,FF,00,... and byte 1023 = FF, then address wraps to 0.
REQ-030 Steady state -> 18 clk between successive data-byte starts, io_sdin never toggles while io_sclk=1.
REQ-031 Reset asserted at data byte 500, bit 3 -> outputs at reset values same cycle; after release full power-up plus 15 commands repeat.

Source files
------------

// File: rtl/screen_pkg.sv
// screen_pkg: driver FSM states, init command count and SSD1306 init ROM with a bounded lookup helper
package screen_pkg;
  typedef enum logic [2:0] {POWER_UP, LOAD_CMD, SEND, CHECK_INIT_DONE, LOAD_DATA} state_t;
  localparam logic [3:0] INIT_CMD_COUNT = 4'd15;
  localparam logic [0:14][7:0] INIT_ROM = {
    8'hAE, 8'hD5, 8'h80, 8'hA8, 8'h3F, 8'hD3, 8'h00, 8'h40,
    8'h8D, 8'h14, 8'h20, 8'h00, 8'hA1, 8'hC8, 8'hAF
  };
  function automatic logic [7:0] init_byte(input logic [3:0] i);
    return i < INIT_CMD_COUNT ? INIT_ROM[i] : 8'h00;
  endfunction
endpackage

// File: rtl/spi_byte_tx.sv
// spi_byte_tx: MSB-first byte serialiser, 2 clk/bit (in: clk, reset, i_load, i_byte; out: o_busy low in last cycle, o_sclk idle high, o_sdin)
module spi_byte_tx (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_load,
  input  logic [7:0] i_byte,
  output logic       o_busy,
  output logic       o_sclk,
  output logic       o_sdin
);
  logic [7:0] r_shift;
  logic [2:0] r_bit;
  logic       r_active;
  logic       r_sclk;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_shift  <= '0;
      r_bit    <= '0;
      r_active <= 1'b0;
      r_sclk   <= 1'b1;
    end else if (i_load) begin
      r_shift  <= i_byte;
      r_bit    <= 3'd7;
      r_active <= 1'b1;
      r_sclk   <= 1'b0;
    end else if (r_active) begin
      if (!r_sclk) r_sclk <= 1'b1;
      else if (r_bit == 3'd0) r_active <= 1'b0;
      else begin
        r_bit   <= r_bit - 3'd1;
        r_sclk  <= 1'b0;
        r_shift <= {r_shift[6:0], 1'b0};
      end
    end
  end
  assign o_busy = r_active && !(r_sclk && r_bit == 3'd0);
  assign o_sclk = r_sclk;
  assign o_sdin = r_shift[7];
endmodule

// File: rtl/screen_driver.sv
// screen_driver: SSD1306 SPI driver, power-up, 15-byte init then endless 1024-byte frames (in: clk, reset, pixel_data; out: io_sclk/io_sdin/io_cs/io_dc/io_reset, pixel_address)
module screen_driver
  import screen_pkg::*;
#(
  parameter logic [31:0] STARTUP_WAIT = 32'd10_000_000
) (
  input  logic       clk,
  input  logic       reset,
  output logic       io_sclk,
  output logic       io_sdin,
  output logic       io_cs,
  output logic       io_dc,
  output logic       io_reset,
  output logic [9:0] pixel_address,
  input  logic [7:0] pixel_data
);
  localparam logic [31:0] W2 = 2 * STARTUP_WAIT;
  localparam logic [31:0] W3 = 3 * STARTUP_WAIT;
  state_t      r_state, w_next;
  logic [31:0] r_cnt;
  logic [3:0]  r_cmd_idx;
  logic        r_cs, r_dc;
  logic [9:0]  r_addr;
  logic        w_load, w_busy;
  logic [7:0]  w_byte;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= POWER_UP;
    else r_state <= w_next;
  end
  always_comb begin
    w_next = r_state;
    w_load = r_state == LOAD_CMD || r_state == LOAD_DATA;
    w_byte = r_state == LOAD_DATA ? pixel_data : init_byte(r_cmd_idx);
    case (r_state)
      POWER_UP:            w_next = r_cnt == W3 ? LOAD_CMD : POWER_UP;
      LOAD_CMD, LOAD_DATA: w_next = SEND;
      SEND:                w_next = w_busy ? SEND : CHECK_INIT_DONE;
      CHECK_INIT_DONE:     w_next = (r_dc || r_cmd_idx == INIT_CMD_COUNT) ? LOAD_DATA : LOAD_CMD;
      default:             w_next = POWER_UP;
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt     <= '0;
      r_cmd_idx <= '0;
      r_cs      <= 1'b1;
      r_dc      <= 1'b0;
      r_addr    <= '0;
    end else begin
      if (r_state == POWER_UP) r_cnt <= r_cnt == W3 ? '0 : r_cnt + 32'd1;
      if (r_state == LOAD_CMD) begin
        r_dc      <= 1'b0;
        r_cmd_idx <= r_cmd_idx + 4'd1;
      end
      if (r_state == LOAD_DATA) begin
        r_dc   <= 1'b1;
        r_addr <= r_addr + 10'd1;
      end
      if (w_load) r_cs <= 1'b0;
    end
  end
  spi_byte_tx u_tx (
    .clk    (clk),
    .reset  (reset),
    .i_load (w_load),
    .i_byte (w_byte),
    .o_busy (w_busy),
    .o_sclk (io_sclk),
    .o_sdin (io_sdin)
  );
  assign io_reset      = !(r_state == POWER_UP && r_cnt >= STARTUP_WAIT && r_cnt < W2);
  assign io_cs         = r_cs;
  assign io_dc         = r_dc;
  assign pixel_address = r_addr;
endmodule

// File: tb/tb_screen_driver.sv
// tb_screen_driver: scoreboard bench for screen_driver with STARTUP_WAIT=4
module tb_screen_driver;
  localparam logic [31:0] SW = 32'd4;
  typedef struct packed {logic dc; logic [7:0] data; logic [9:0] addr;} exp_t;
  typedef struct packed {logic dc; logic [7:0] data; logic [9:0] addr; logic [31:0] cyc;} obs_t;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       io_sclk, io_sdin, io_cs, io_dc, io_reset;
  logic [9:0] pixel_address;
  logic [7:0] pixel_data = 8'h00;
  int checks = 0;
  int failures = 0;
  logic [31:0] cyc = 0;
  logic [31:0] last_cyc = 0;
  exp_t exp_q[$];
  obs_t obs_q[$];
  logic [7:0] rom [15] = '{8'hAE, 8'hD5, 8'h80, 8'hA8, 8'h3F, 8'hD3, 8'h00, 8'h40,
                           8'h8D, 8'h14, 8'h20, 8'h00, 8'hA1, 8'hC8, 8'hAF};
  logic       prev_sclk = 1'b1, prev_sdin = 1'b0, prev_dc = 1'b0;
  logic [7:0] sh = 8'h00;
  int nb = 0, n_data = 0, sdin_viol = 0, dc_viol = 0;

  always #5 clk = ~clk;

  screen_driver #(.STARTUP_WAIT(SW)) dut (
    .clk           (clk),
    .reset         (reset),
    .io_sclk       (io_sclk),
    .io_sdin       (io_sdin),
    .io_cs         (io_cs),
    .io_dc         (io_dc),
    .io_reset      (io_reset),
    .pixel_address (pixel_address),
    .pixel_data    (pixel_data)
  );

  always @(posedge clk) begin
    pixel_data <= pixel_address[7:0];
    cyc <= cyc + 1;
  end

  always @(negedge clk) begin
    if (reset) begin
      nb = 0;
      n_data = 0;
    end else begin
      if (io_sdin !== prev_sdin && io_sclk === 1'b1) sdin_viol++;
      if (io_dc !== prev_dc && nb != 0) dc_viol++;
      if (prev_sclk === 1'b0 && io_sclk === 1'b1) begin
        sh = {sh[6:0], io_sdin};
        nb++;
        if (nb == 8) begin
          obs_q.push_back({io_dc, sh, pixel_address, cyc});
          nb = 0;
          if (io_dc) n_data++;
        end
      end
    end
    prev_sclk = io_sclk;
    prev_sdin = io_sdin;
    prev_dc   = io_dc;
  end

  task automatic pop_obs(output obs_t o, output bit ok);
    int t = 0;
    while (obs_q.size() == 0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    ok = obs_q.size() != 0;
    o = ok ? obs_q.pop_front() : '0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({io_reset, io_cs, io_sclk, io_sdin, io_dc} !== 5'b11100) begin
      failures++;
      $display("FAIL reset_ctrl got=%b want=11100", {io_reset, io_cs, io_sclk, io_sdin, io_dc});
    end
    checks++;
    if (pixel_address !== 10'd0) begin
      failures++;
      $display("FAIL reset_addr got=%0d want=0", pixel_address);
    end
  endtask

  task automatic test_power_up;
    int hi = 0, lo = 0, hi2 = 0;
    @(negedge clk);
    reset = 1'b0;
    while (io_reset === 1'b1 && hi < 50) begin hi++; @(negedge clk); end
    while (io_reset === 1'b0 && lo < 50) begin lo++; @(negedge clk); end
    while (io_reset === 1'b1 && io_cs === 1'b1 && hi2 < 50) begin hi2++; @(negedge clk); end
    checks++;
    if (hi != SW) begin
      failures++;
      $display("FAIL pwr_high1 got=%0d want=%0d", hi, SW);
    end
    checks++;
    if (lo != SW) begin
      failures++;
      $display("FAIL pwr_low got=%0d want=%0d", lo, SW);
    end
    checks++;
    if (hi2 < SW || hi2 > SW + 2 || io_cs !== 1'b0 || io_reset !== 1'b1) begin
      failures++;
      $display("FAIL pwr_high2_cs got=%0d cs=%b rst=%b want=%0d..%0d cs=0 rst=1", hi2, io_cs, io_reset, SW, SW + 2);
    end
  endtask

  task automatic test_init_cmds;
    obs_t o;
    exp_t e;
    bit ok;
    for (int k = 0; k < 15; k++) exp_q.push_back({1'b0, rom[k], 10'd0});
    for (int k = 0; k < 15; k++) begin
      e = exp_q.pop_front();
      pop_obs(o, ok);
      checks++;
      if (!ok) begin
        failures++;
        $display("FAIL init_timeout k=%0d got=none want=%h", k, e.data);
        break;
      end
      if ({o.dc, o.data, o.addr} !== e) begin
        failures++;
        $display("FAIL init_cmd k=%0d got dc=%b byte=%h addr=%0d want dc=%b byte=%h addr=%0d", k, o.dc, o.data, o.addr, e.dc, e.data, e.addr);
      end
      if (k > 0) begin
        checks++;
        if (o.cyc - last_cyc != 32'd18) begin
          failures++;
          $display("FAIL init_gap k=%0d got=%0d want=18", k, o.cyc - last_cyc);
        end
      end
      last_cyc = o.cyc;
    end
  endtask

  task automatic test_data(input int n);
    obs_t o;
    exp_t e;
    bit ok;
    for (int k = 0; k < n; k++) exp_q.push_back({1'b1, 8'(k), 10'(k + 1)});
    for (int k = 0; k < n; k++) begin
      e = exp_q.pop_front();
      pop_obs(o, ok);
      checks++;
      if (!ok) begin
        failures++;
        $display("FAIL data_timeout k=%0d got=none want=%h", k, e.data);
        break;
      end
      if ({o.dc, o.data, o.addr} !== e) begin
        failures++;
        $display("FAIL data_byte k=%0d got dc=%b byte=%h addr=%0d want dc=%b byte=%h addr=%0d", k, o.dc, o.data, o.addr, e.dc, e.data, e.addr);
      end
      checks++;
      if (o.cyc - last_cyc != 32'd18) begin
        failures++;
        $display("FAIL data_gap k=%0d got=%0d want=18", k, o.cyc - last_cyc);
      end
      last_cyc = o.cyc;
    end
  endtask

  task automatic test_bus_rules;
    checks++;
    if (sdin_viol != 0) begin
      failures++;
      $display("FAIL sdin_while_sclk_high got=%0d want=0", sdin_viol);
    end
    checks++;
    if (dc_viol != 0) begin
      failures++;
      $display("FAIL dc_mid_byte got=%0d want=0", dc_viol);
    end
  endtask

  task automatic test_mid_reset;
    int t = 0;
    do begin
      @(negedge clk);
      #1;
      t++;
    end while (!((n_data % 1024) == 500 && nb == 4 && io_sclk === 1'b0) && t < 30000);
    checks++;
    if (t >= 30000) begin
      failures++;
      $display("FAIL midreset_reach got=timeout want=byte500_bit3");
    end
    reset = 1'b1;
    #1;
    checks++;
    if ({io_reset, io_cs, io_sclk, io_sdin, io_dc} !== 5'b11100) begin
      failures++;
      $display("FAIL midreset_ctrl got=%b want=11100", {io_reset, io_cs, io_sclk, io_sdin, io_dc});
    end
    checks++;
    if (pixel_address !== 10'd0) begin
      failures++;
      $display("FAIL midreset_addr got=%0d want=0", pixel_address);
    end
    obs_q.delete();
    exp_q.delete();
    repeat (2) @(negedge clk);
  endtask

  initial begin
    test_reset;
    test_power_up;
    test_init_cmds;
    test_data(1030);
    test_bus_rules;
    test_mid_reset;
    test_power_up;
    test_init_cmds;
    test_data(4);
    test_bus_rules;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
